piso_tx_sched: RTL and testbench

Two-requester transmit scheduler for the 4-bit parallel-in serial-out shift register. It arbitrates round-robin between two word sources and drives the PISO's `load`/`din` inputs. It then counts the shift cycles and flags which serial bit on `dout` is valid, last, and from which source. It sits directly in front of the PISO; the PISO's `clock`/`rst` are driven from the same nets as this block.

---
 rtl/piso_tx_sched.sv | 138 +++++++++++++
 tb/tb_piso_tx_sched.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_tx_sched.sv
// Round-robin transmit scheduler for a WIDTH-bit PISO: grants one of two word sources,
// drives the PISO load/din, then flags valid/last/source for each serial bit on dout.
module piso_tx_sched #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned GAP   = 1
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    output logic             ack0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             ack1,
    output logic             piso_load,
    output logic [WIDTH-1:0] piso_din,
    output logic             tx_valid,
    output logic             tx_last,
    output logic             tx_src,
    output logic             busy
);

    localparam int unsigned     CntW    = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);
    localparam logic [3:0]      GapLast = 4'(GAP - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StGap} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
    logic             last_src_q, last_src_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             piso_load_q, piso_load_d;
    logic [WIDTH-1:0] piso_din_q, piso_din_d;
    logic             tx_valid_q, tx_valid_d;
    logic             tx_last_q, tx_last_d;
    logic             tx_src_q, tx_src_d;
    logic             busy_q, busy_d;
    logic             any_req;
    logic             winner;

    always_comb begin
        any_req     = req0 | req1;
        // On a tie the source that did not win last time goes next.
        winner      = (req0 & req1) ? ~last_src_q : req1;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        last_src_d  = last_src_q;
        piso_din_d  = piso_din_q;
        tx_src_d    = tx_src_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        piso_load_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d     = StLoad;
                    piso_load_d = 1'b1;
                    ack0_d      = ~winner;
                    ack1_d      = winner;
                    piso_din_d  = winner ? data1 : data0;
                    tx_src_d    = winner;
                    last_src_d  = winner;
                end
            end
            StLoad: begin
                state_d   = StShift;
                bit_cnt_d = '0;
            end
            StShift: begin
                if (bit_cnt_q == LastBit) begin
                    state_d   = (GAP > 0) ? StGap : StIdle;
                    bit_cnt_d = '0;
                    gap_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            StGap: begin
                if (gap_cnt_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Status outputs are registered from the next state so they align with dout.
        tx_valid_d = (state_d == StShift);
        tx_last_d  = tx_valid_d && (bit_cnt_d == LastBit);
        busy_d     = (state_d != StIdle);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            last_src_q  <= 1'b1;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            piso_load_q <= 1'b0;
            piso_din_q  <= '0;
            tx_valid_q  <= 1'b0;
            tx_last_q   <= 1'b0;
            tx_src_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            last_src_q  <= last_src_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            piso_load_q <= piso_load_d;
            piso_din_q  <= piso_din_d;
            tx_valid_q  <= tx_valid_d;
            tx_last_q   <= tx_last_d;
            tx_src_q    <= tx_src_d;
            busy_q      <= busy_d;
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign piso_load = piso_load_q;
    assign piso_din  = piso_din_q;
    assign tx_valid  = tx_valid_q;
    assign tx_last   = tx_last_q;
    assign tx_src    = tx_src_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_piso_tx_sched.sv
// Bench for piso_tx_sched: default 4-bit/GAP=1 instance checked by a frame scoreboard,
// plus an 8-bit/GAP=0 instance for the parameterisation case.
module tb_piso_tx_sched;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clock) cyc++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- instance A: WIDTH=4, GAP=1 ----------------
    logic       rst, req0, req1, ack0, ack1, piso_load, tx_valid, tx_last, tx_src, busy;
    logic [3:0] data0, data1, piso_din, piso_q;

    piso_tx_sched #(.WIDTH(4), .GAP(1)) u_dut (
        .clock     (clock),
        .rst       (rst),
        .req0      (req0),
        .data0     (data0),
        .ack0      (ack0),
        .req1      (req1),
        .data1     (data1),
        .ack1      (ack1),
        .piso_load (piso_load),
        .piso_din  (piso_din),
        .tx_valid  (tx_valid),
        .tx_last   (tx_last),
        .tx_src    (tx_src),
        .busy      (busy)
    );

    // Downstream PISO: load captures din, otherwise shift left, dout is the MSB.
    always @(posedge clock) begin
        if (rst) piso_q <= '0;
        else if (piso_load) piso_q <= piso_din;
        else piso_q <= {piso_q[2:0], 1'b0};
    end
    wire dout = piso_q[3];

    // ---------------- instance B: WIDTH=8, GAP=0 ----------------
    logic       rst_b, req0_b, req1_b, ack0_b, ack1_b, load_b, valid_b, last_b, src_b, busy_b;
    logic [7:0] data0_b, data1_b, din_b, piso_b;

    piso_tx_sched #(.WIDTH(8), .GAP(0)) u_dut_b (
        .clock     (clock),
        .rst       (rst_b),
        .req0      (req0_b),
        .data0     (data0_b),
        .ack0      (ack0_b),
        .req1      (req1_b),
        .data1     (data1_b),
        .ack1      (ack1_b),
        .piso_load (load_b),
        .piso_din  (din_b),
        .tx_valid  (valid_b),
        .tx_last   (last_b),
        .tx_src    (src_b),
        .busy      (busy_b)
    );

    always @(posedge clock) begin
        if (rst_b) piso_b <= '0;
        else if (load_b) piso_b <= din_b;
        else piso_b <= {piso_b[6:0], 1'b0};
    end
    wire dout_b = piso_b[7];

    // ---------------- scoreboard for instance A ----------------
    typedef struct packed {
        logic       src;
        logic [3:0] data;
    } frame_t;

    frame_t exp_q[$];
    frame_t cur;
    logic   in_frame = 1'b0;
    int     bit_idx  = 0;

    always @(negedge clock) begin
        check_eq("ack_exclusive", 32'(ack0 & ack1), 32'd0);
        check_eq("load_vs_valid", 32'(piso_load & tx_valid), 32'd0);
        if (ack0 | ack1) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_ack", 32'({ack1, ack0}), 32'd0);
            end else begin
                cur = exp_q.pop_front();
                check_eq("grant_src", 32'(ack1), 32'(cur.src));
                check_eq("grant_tx_src", 32'(tx_src), 32'(cur.src));
                check_eq("grant_din", 32'(piso_din), 32'(cur.data));
                check_eq("grant_load", 32'(piso_load), 32'd1);
                in_frame = 1'b1;
                bit_idx  = 0;
            end
        end else if (tx_valid) begin
            if (!in_frame) begin
                check_eq("stray_valid", 32'(tx_valid), 32'd0);
            end else begin
                check_eq("dout_bit", 32'(dout), 32'(cur.data[3 - bit_idx]));
                check_eq("bit_src", 32'(tx_src), 32'(cur.src));
                check_eq("bit_last", 32'(tx_last), 32'(bit_idx == 3));
                bit_idx++;
                if (bit_idx == 4) in_frame = 1'b0;
            end
        end
    end

    task automatic wait_ack(input int limit);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(ack0 | ack1) && n < limit);
        if (!(ack0 | ack1)) check_eq("ack_timeout", 32'(ack0 | ack1), 32'd1);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (busy && n < limit);
        check_eq("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic push_frame(input logic src, input logic [3:0] data);
        frame_t f;
        f.src  = src;
        f.data = data;
        exp_q.push_back(f);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          t0;
        int          n;
        logic [7:0]  pat_b;

        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
        rst_b = 1'b1; req0_b = 1'b0; req1_b = 1'b0; data0_b = '0; data1_b = '0;

        // Reset defaults with a request pending, then first grant and single frame.
        req0 = 1'b1; data0 = 4'b0101;
        repeat (2) begin
            @(negedge clock);
            check_eq("rst_outputs",
                     32'({ack0, ack1, piso_load, tx_valid, tx_last, tx_src, busy, piso_din}), 32'd0);
        end
        push_frame(1'b0, 4'b0101);
        @(posedge clock); #1 rst = 1'b0;
        @(negedge clock); check_eq("ack_not_early", 32'(ack0), 32'd0);
        @(negedge clock); check_eq("ack_after_rst", 32'(ack0), 32'd1);
        @(posedge clock); #1 req0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock); check_eq("sf_valid", 32'(tx_valid), 32'd1);
        end
        @(negedge clock); check_eq("sf_gap", 32'({busy, tx_valid}), 32'b10);
        @(negedge clock); check_eq("sf_idle", 32'(busy), 32'd0);

        // Tie fairness from reset: 0,1,0,1 at a 7-cycle period.
        @(posedge clock); #1;
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; data0 = 4'b1110; data1 = 4'b0011;
        push_frame(1'b0, 4'b1110); push_frame(1'b1, 4'b0011);
        push_frame(1'b0, 4'b1110); push_frame(1'b1, 4'b0011);
        @(posedge clock); #1 rst = 1'b0;
        t0 = 0;
        for (int k = 0; k < 4; k++) begin
            wait_ack(20);
            if (k > 0) check_eq("tie_period", 32'(cyc - t0), 32'd7);
            t0 = cyc;
        end
        @(posedge clock); #1 req0 = 1'b0; req1 = 1'b0;
        wait_idle(20);

        // Late request during SHIFT waits for IDLE.
        @(posedge clock); #1 req0 = 1'b1; data0 = 4'b1100;
        push_frame(1'b0, 4'b1100);
        wait_ack(20);
        t0 = cyc;
        @(posedge clock); #1 req0 = 1'b0;
        @(negedge clock);
        @(posedge clock); #1 req1 = 1'b1; data1 = 4'b1001;
        push_frame(1'b1, 4'b1001);
        wait_ack(20);
        check_eq("late_ack1", 32'(ack1), 32'd1);
        check_eq("late_latency", 32'(cyc - t0), 32'd7);
        @(posedge clock); #1 req1 = 1'b0;
        wait_idle(20);

        // Reset mid-frame aborts, then a lone held req1 wins.
        @(posedge clock); #1 req0 = 1'b1; data0 = 4'b1010;
        push_frame(1'b0, 4'b1010);
        wait_ack(20);
        @(posedge clock); #1 req0 = 1'b0; req1 = 1'b1; data1 = 4'b0110;
        push_frame(1'b1, 4'b0110);
        @(negedge clock);
        @(negedge clock);
        #1 rst = 1'b1;
        @(posedge clock); #1 rst = 1'b0;
        in_frame = 1'b0;
        @(negedge clock);
        check_eq("abort_valid", 32'(tx_valid), 32'd0);
        check_eq("abort_noack", 32'({ack1, ack0}), 32'd0);
        @(negedge clock);
        check_eq("post_rst_grant", 32'({ack1, ack0}), 32'b10);
        @(posedge clock); #1 req1 = 1'b0;
        wait_idle(20);
        check_eq("sb_drain", 32'(exp_q.size()), 32'd0);

        // WIDTH=8, GAP=0: back-to-back frames every 10 cycles.
        pat_b = 8'hA5;
        @(posedge clock); #1 rst_b = 1'b0; req0_b = 1'b1; data0_b = pat_b;
        t0 = 0;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin
                @(negedge clock);
                n++;
            end while (!ack0_b && n < 30);
            check_eq("b_ack", 32'(ack0_b), 32'd1);
            check_eq("b_din", 32'(din_b), 32'(pat_b));
            if (k > 0) check_eq("b_period", 32'(cyc - t0), 32'd10);
            t0 = cyc;
            for (int i = 0; i < 8; i++) begin
                @(negedge clock);
                check_eq("b_valid", 32'(valid_b), 32'd1);
                check_eq("b_dout", 32'(dout_b), 32'(pat_b[7 - i]));
                check_eq("b_last", 32'(last_b), 32'(i == 7));
            end
        end
        @(posedge clock); #1 req0_b = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
